// File: rtl/ipsxe_floating_point_invsqrt_pack_v1_0.sv
`default_nettype none
// ============================================================================
// Module   : ipsxe_floating_point_invsqrt_pack_v1_0
// Desc     : invsqrt output stage - aligns side info with the rounding APM,
//            applies IEEE specials, packs the word into a credit-based FIFO.
//            Optional macro INVSQRT_PACK_FLAGS_EN adds o_flags {invalid, divbyzero}.
// Revision : 1.0 - initial release
// ============================================================================
module ipsxe_floating_point_invsqrt_pack_v1_0 #(
    parameter int EXP_WIDTH   = 8,
    parameter int MAN_WIDTH   = 23,
    parameter int APM_LATENCY = 2,
    parameter int DEPTH       = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    input  logic                           i_sign,
    input  logic [EXP_WIDTH-1:0]           i_exp,
    input  logic [1:0]                     i_class,
    input  logic [MAN_WIDTH+1:0]           i_z_rnd,
    output logic                           o_in_ready,
    output logic                           o_valid,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   o_result,
`ifdef INVSQRT_PACK_FLAGS_EN
    output logic [1:0]                     o_flags,
`endif
    input  logic                           i_ready
);

    localparam int RES_W  = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int SIDE_W = 1 + EXP_WIDTH + 2;
`ifdef INVSQRT_PACK_FLAGS_EN
    localparam int ENTRY_W = RES_W + 2;
`else
    localparam int ENTRY_W = RES_W;
`endif
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = $clog2(DEPTH + APM_LATENCY + 2) + 1;

    logic                 accept;
    logic [SIDE_W-1:0]    in_side;
    logic                 tap_valid;
    logic [SIDE_W-1:0]    tap_side;
    logic [SUM_W-1:0]     a_inflight;

    // Words offered without credit are dropped here and never enter the pipe.
    assign accept  = i_valid && o_in_ready;
    assign in_side = {i_sign, i_exp, i_class};

    generate
        if (APM_LATENCY == 0) begin : g_no_delay
            assign tap_valid  = accept;
            assign tap_side   = in_side;
            assign a_inflight = '0;
        end else begin : g_delay
            logic [APM_LATENCY-1:0] dv;
            logic [SIDE_W-1:0]      ds [APM_LATENCY];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    dv <= '0;
                end else begin
                    dv[0] <= accept;
                    for (int i = 1; i < APM_LATENCY; i++) begin
                        dv[i] <= dv[i-1];
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                ds[0] <= in_side;
                for (int i = 1; i < APM_LATENCY; i++) begin
                    ds[i] <= ds[i-1];
                end
            end

            always_comb begin
                a_inflight = '0;
                for (int i = 0; i < APM_LATENCY; i++) begin
                    a_inflight = a_inflight + SUM_W'(dv[i]);
                end
            end

            assign tap_valid = dv[APM_LATENCY-1];
            assign tap_side  = ds[APM_LATENCY-1];
        end
    endgenerate

    logic                 t_sign;
    logic [EXP_WIDTH-1:0] t_exp;
    logic [EXP_WIDTH-1:0] exp_inc;
    logic [1:0]           t_class;
    logic [RES_W-1:0]     next_result;
    logic                 unused_hidden;

    assign t_sign        = tap_side[SIDE_W-1];
    assign t_exp         = tap_side[SIDE_W-2:2];
    assign t_class       = tap_side[1:0];
    assign exp_inc       = t_exp + EXP_WIDTH'(1);
    assign unused_hidden = i_z_rnd[MAN_WIDTH];

    // A carry into an exponent of all-ones naturally encodes +inf with frac=0.
    always_comb begin
        next_result = '0;
        case (t_class)
            2'b00: begin
                if (i_z_rnd[MAN_WIDTH+1]) begin
                    next_result = {1'b0, exp_inc, {MAN_WIDTH{1'b0}}};
                end else begin
                    next_result = {1'b0, t_exp, i_z_rnd[MAN_WIDTH-1:0]};
                end
            end
            2'b01:   next_result = {t_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            2'b10:   next_result = '0;
            default: next_result = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
        endcase
    end

    logic               b_valid;
    logic [RES_W-1:0]   b_result;
    logic [ENTRY_W-1:0] entry_in;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            b_valid <= 1'b0;
        end else begin
            b_valid <= tap_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        b_result <= next_result;
    end

`ifdef INVSQRT_PACK_FLAGS_EN
    logic [1:0] b_flags;

    always_ff @(posedge i_clk) begin
        b_flags <= {t_class == 2'b11, t_class == 2'b01};
    end

    assign entry_in = {b_flags, b_result};
`else
    assign entry_in = b_result;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop  = o_valid && i_ready;
    assign push = b_valid && ((count < CNT_W'(DEPTH)) || pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    assign head     = mem[rd_ptr];
    assign o_valid  = (count != '0);
    assign o_result = o_valid ? head[RES_W-1:0] : '0;
`ifdef INVSQRT_PACK_FLAGS_EN
    assign o_flags  = o_valid ? head[ENTRY_W-1 -: 2] : 2'b00;
`endif

    // Credit counts every accepted word not yet popped; a same-cycle pop is ignored.
    assign o_in_ready = (SUM_W'(count) + a_inflight + SUM_W'(b_valid)) < SUM_W'(DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_ipsxe_floating_point_invsqrt_pack_v1_0.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipsxe_floating_point_invsqrt_pack_v1_0
// Desc     : Self-checking bench with a queue-based model of the pack stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipsxe_floating_point_invsqrt_pack_v1_0;

    localparam int L     = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_sign = 1'b0;
    logic [7:0]  i_exp = '0;
    logic [1:0]  i_class = '0;
    logic [24:0] i_z_rnd = '0;
    logic        i_ready = 1'b0;
    logic        o_in_ready;
    logic        o_valid;
    logic [31:0] o_result;
`ifdef INVSQRT_PACK_FLAGS_EN
    logic [1:0]  o_flags;
`endif

    ipsxe_floating_point_invsqrt_pack_v1_0 #(
        .EXP_WIDTH(8), .MAN_WIDTH(23), .APM_LATENCY(L), .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_valid(i_valid),
        .i_sign(i_sign),
        .i_exp(i_exp),
        .i_class(i_class),
        .i_z_rnd(i_z_rnd),
        .o_in_ready(o_in_ready),
        .o_valid(o_valid),
        .o_result(o_result),
`ifdef INVSQRT_PACK_FLAGS_EN
        .o_flags(o_flags),
`endif
        .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  flg;
        int          vis;
    } exp_t;

    exp_t        q[$];
    logic [24:0] sched_z[int];
    logic [24:0] cur_z = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Result word straight from the IEEE rules for each operand class.
    function automatic logic [31:0] model(input bit s, input int e, input logic [1:0] c,
                                          input logic [24:0] z);
        case (c)
            2'd0: begin
                if (z[24]) begin
                    if (e + 1 >= 255) return 32'h7F80_0000;
                    return (32'(e + 1) << 23);
                end
                return (32'(e) << 23) | 32'(z[22:0]);
            end
            2'd1:    return s ? 32'hFF80_0000 : 32'h7F80_0000;
            2'd2:    return 32'h0000_0000;
            default: return 32'h7FC0_0000;
        endcase
    endfunction

    function automatic logic [1:0] model_flags(input logic [1:0] c);
        return (c == 2'd3) ? 2'b10 : (c == 2'd1) ? 2'b01 : 2'b00;
    endfunction

    // Every accepted word becomes visible exactly L+2 cycles later, in order.
    always @(negedge clk) begin
        if (chk_en) begin
            bit   exp_rdy;
            bit   exp_vld;
            exp_t e;
            exp_rdy = (q.size() < DEPTH);
            chk("in_ready", 64'(o_in_ready), 64'(exp_rdy));
            exp_vld = (q.size() > 0) && (cyc >= q[0].vis);
            chk("valid", 64'(o_valid), 64'(exp_vld));
            if (exp_vld) begin
                chk("result", 64'(o_result), 64'(q[0].res));
`ifdef INVSQRT_PACK_FLAGS_EN
                chk("flags", 64'(o_flags), 64'(q[0].flg));
`endif
            end
            if (i_rst) begin
                q.delete();
            end else begin
                if (exp_vld && i_ready) void'(q.pop_front());
                if (i_valid && exp_rdy) begin
                    e.res = model(i_sign, int'(i_exp), i_class, cur_z);
                    e.flg = model_flags(i_class);
                    e.vis = cyc + L + 2;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input bit v, input bit s, input logic [7:0] e, input logic [1:0] c,
                         input logic [24:0] z, input bit rdy, input bit rst, input bit only_rdy);
        @(posedge clk);
        #1;
        i_valid = v && (!only_rdy || o_in_ready);
        i_sign  = s;
        i_exp   = e;
        i_class = c;
        i_ready = rdy;
        i_rst   = rst;
        cur_z   = z;
        if (i_valid) sched_z[cyc + L] = z;
        if (sched_z.exists(cyc)) begin
            i_z_rnd = sched_z[cyc];
            sched_z.delete(cyc);
        end else begin
            i_z_rnd = 25'($urandom);
        end
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 1'($urandom), 8'($urandom), 2'($urandom), 25'($urandom), rdy, 1'b0, 1'b0);
    endtask

    task automatic single(input bit s, input logic [7:0] e, input logic [1:0] c,
                          input logic [24:0] z, input logic [31:0] req, input logic [1:0] rflg,
                          input string name);
        drive(1'b1, s, e, c, z, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < L + 2; k++) idle(1'b1);
        @(negedge clk);
        chk({name, "_valid"}, 64'(o_valid), 64'd1);
        chk(name, 64'(o_result), 64'(req));
`ifdef INVSQRT_PACK_FLAGS_EN
        chk({name, "_flags"}, 64'(o_flags), 64'(rflg));
`else
        if (rflg == 2'b11) $display("unexpected flag pattern");
`endif
    endtask

    initial begin
        int acc_cnt;
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 8'd0, 2'd0, 25'd0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        chk_en = 1;
        @(negedge clk);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_result", 64'(o_result), 64'd0);
        chk("reset_in_ready", 64'(o_in_ready), 64'd1);

        single(1'b0, 8'd126, 2'd0, {2'b01, 23'h0},      32'h3F00_0000, 2'b00, "normal");
        single(1'b1, 8'd126, 2'd0, {1'b1, 24'h0},       32'h3F80_0000, 2'b00, "carry");
        single(1'b0, 8'd254, 2'd0, {1'b1, 24'h0},       32'h7F80_0000, 2'b00, "carry_ovf");
        single(1'b0, 8'd100, 2'd1, 25'h1FFFFFF,         32'h7F80_0000, 2'b01, "zero_pos");
        single(1'b1, 8'd100, 2'd1, 25'h0ABCDEF,         32'hFF80_0000, 2'b01, "zero_neg");
        single(1'b1, 8'd3,   2'd2, 25'h1555555,         32'h0000_0000, 2'b00, "pinf");
        single(1'b1, 8'd77,  2'd3, 25'h0123456,         32'h7FC0_0000, 2'b10, "nan");

        // Backpressure: exactly DEPTH words fit, then credit stays closed.
        for (int k = 0; k < 6; k++) idle(1'b1);
        acc_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, 8'(10 + k), 2'd0, {2'b01, 23'($urandom)}, 1'b0, 1'b0, 1'b1);
            if (i_valid) acc_cnt++;
        end
        chk("bp_accepted", 64'(acc_cnt), 64'(DEPTH));
        @(negedge clk);
        chk("bp_in_ready_low", 64'(o_in_ready), 64'd0);
        for (int k = 0; k < DEPTH; k++) idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        chk("bp_drained", 64'(o_valid), 64'd0);

        // Reset with two words queued and two in flight.
        for (int k = 0; k < 2; k++) drive(1'b1, 1'b0, 8'(50 + k), 2'd0, {2'b01, 23'($urandom)}, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        for (int k = 0; k < 2; k++) drive(1'b1, 1'b0, 8'(60 + k), 2'd0, {2'b01, 23'($urandom)}, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 2'd0, 25'd0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("rst_mid_valid", 64'(o_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(o_in_ready), 64'd1);
        for (int k = 0; k < 8; k++) idle(1'b1);

        // Back-to-back normals; the compare process checks consecutive output.
        for (int k = 0; k < 8; k++)
            drive(1'b1, 1'b0, 8'(120 + k), 2'd0, {1'b0, 1'b1, 23'($urandom)}, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) idle(1'b1);

        // Randomized traffic including protocol violations and occasional resets.
        for (int k = 0; k < 1500; k++) begin
            bit          rst;
            logic [1:0]  c;
            logic [24:0] z;
            rst = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            z   = ($urandom_range(0, 3) == 0) ? {1'b1, 24'($urandom)} : {2'b01, 23'($urandom)};
            drive(!rst && ($urandom_range(0, 9) < 6), 1'($urandom), 8'($urandom_range(1, 254)),
                  c, z, ($urandom_range(0, 9) < 6), rst, 1'b0);
        end
        for (int k = 0; k < 12; k++) idle(1'b1);
        @(negedge clk);
        chk("final_empty", 64'(o_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
